// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, variable-latency memory bus between the CPU
// instruction-fetch port and its load/store port. Only one access is ever in
// flight. Data wins ties, but after MAX_DATA_BURST consecutive data grants
// with a fetch waiting, the next grant goes to fetch. An access that is not
// acked within TIMEOUT bus cycles is aborted and reported with an error.
//
// Parameters
//   MAX_DATA_BURST  data grants allowed in a row while fetch is pending
//   TIMEOUT         bus cycles to wait for i_bus_ack (1..255)
//
// Ports
//   i_clk, rst           clock (rising edge) and synchronous active-high reset
//   i_inst_*             fetch request: req, addr
//   o_inst_*             fetch grant pulse, rvalid pulse, rdata, err
//   i_data_*             load/store request: req, addr, wdata, width, we,
//                        zeroextend
//   o_data_*             data grant pulse, rvalid pulse, rdata, err
//   o_bus_*              access in flight (req) and its latched fields
//   i_bus_ack/rdata      access completion and read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_DATA_BURST = 4,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic        i_clk,
    input  logic        rst,

    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic        o_inst_gnt,
    output logic        o_inst_rvalid,
    output logic [31:0] o_inst_rdata,
    output logic        o_inst_err,

    input  logic        i_data_req,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    input  logic [1:0]  i_data_width,
    input  logic        i_data_we,
    input  logic        i_data_zeroextend,
    output logic        o_data_gnt,
    output logic        o_data_rvalid,
    output logic [31:0] o_data_rdata,
    output logic        o_data_err,

    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [1:0]  o_bus_width,
    output logic        o_bus_we,
    output logic        o_bus_zeroextend,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [7:0] MaxBurst = 8'(MAX_DATA_BURST);
    // Last unacked cycle before abort: the access may stay on the bus for
    // exactly TIMEOUT cycles, and an ack in that final cycle still counts.
    localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;

    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  bus_width_q, bus_width_d;
    logic        bus_we_q, bus_we_d;
    logic        bus_ze_q, bus_ze_d;

    logic        inst_rvalid_q, inst_rvalid_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic        inst_err_q, inst_err_d;
    logic        data_rvalid_q, data_rvalid_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        data_err_q, data_err_d;

    logic        grant_inst;
    logic        grant_data;
    logic        fetch_starved;

    assign fetch_starved = i_inst_req && (burst_cnt_q == MaxBurst);

    // -----------------------------------------------------------------------
    // Next-state, grant and completion logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_width_d   = bus_width_q;
        bus_we_d      = bus_we_q;
        bus_ze_d      = bus_ze_q;
        inst_rvalid_d = 1'b0;
        inst_rdata_d  = 32'h0;
        inst_err_d    = 1'b0;
        data_rvalid_d = 1'b0;
        data_rdata_d  = 32'h0;
        data_err_d    = 1'b0;
        grant_inst    = 1'b0;
        grant_data    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_data_req && !fetch_starved) begin
                    grant_data = 1'b1;
                end else if (i_inst_req) begin
                    grant_inst = 1'b1;
                end

                if (grant_data) begin
                    state_d     = StBusyD;
                    tmo_cnt_d   = 8'h0;
                    bus_addr_d  = i_data_addr;
                    bus_wdata_d = i_data_wdata;
                    bus_width_d = i_data_width;
                    bus_we_d    = i_data_we;
                    bus_ze_d    = i_data_zeroextend;
                    // Only data grants that make fetch wait count toward the burst.
                    if (i_inst_req && (burst_cnt_q < MaxBurst)) begin
                        burst_cnt_d = burst_cnt_q + 8'h1;
                    end
                end else if (grant_inst) begin
                    state_d     = StBusyI;
                    tmo_cnt_d   = 8'h0;
                    burst_cnt_d = 8'h0;
                    bus_addr_d  = i_inst_addr;
                    bus_wdata_d = 32'h0;
                    bus_width_d = 2'd2;
                    bus_we_d    = 1'b0;
                    bus_ze_d    = 1'b0;
                end

                if (!i_inst_req) begin
                    burst_cnt_d = 8'h0;
                end
            end

            StBusyI, StBusyD: begin
                if (i_bus_ack) begin
                    state_d = StIdle;
                    if (state_q == StBusyI) begin
                        inst_rvalid_d = 1'b1;
                        inst_rdata_d  = i_bus_rdata;
                    end else begin
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = bus_we_q ? 32'h0 : i_bus_rdata;
                    end
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d = StIdle;
                    if (state_q == StBusyI) begin
                        inst_rvalid_d = 1'b1;
                        inst_err_d    = 1'b1;
                    end else begin
                        data_rvalid_d = 1'b1;
                        data_err_d    = 1'b1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'h1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q       <= StIdle;
            burst_cnt_q   <= 8'h0;
            tmo_cnt_q     <= 8'h0;
            bus_addr_q    <= 32'h0;
            bus_wdata_q   <= 32'h0;
            bus_width_q   <= 2'd0;
            bus_we_q      <= 1'b0;
            bus_ze_q      <= 1'b0;
            inst_rvalid_q <= 1'b0;
            inst_rdata_q  <= 32'h0;
            inst_err_q    <= 1'b0;
            data_rvalid_q <= 1'b0;
            data_rdata_q  <= 32'h0;
            data_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_width_q   <= bus_width_d;
            bus_we_q      <= bus_we_d;
            bus_ze_q      <= bus_ze_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_rdata_q  <= inst_rdata_d;
            inst_err_q    <= inst_err_d;
            data_rvalid_q <= data_rvalid_d;
            data_rdata_q  <= data_rdata_d;
            data_err_q    <= data_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Grants are combinational from IDLE; suppressed while reset is applied so
    // that nothing is accepted in a cycle that is about to be wiped.
    assign o_inst_gnt       = grant_inst && !rst;
    assign o_data_gnt       = grant_data && !rst;

    assign o_inst_rvalid    = inst_rvalid_q;
    assign o_inst_rdata     = inst_rdata_q;
    assign o_inst_err       = inst_err_q;
    assign o_data_rvalid    = data_rvalid_q;
    assign o_data_rdata     = data_rdata_q;
    assign o_data_err       = data_err_q;

    assign o_bus_req        = (state_q != StIdle);
    assign o_bus_addr       = bus_addr_q;
    assign o_bus_wdata      = bus_wdata_q;
    assign o_bus_width      = bus_width_q;
    assign o_bus_we         = bus_we_q;
    assign o_bus_zeroextend = bus_ze_q;

    // -----------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!rst) begin
            assert (!(o_inst_gnt && o_data_gnt))
                else $error("both grants asserted");
            assert (!(o_inst_rvalid && o_data_rvalid))
                else $error("both rvalids asserted");
            assert (!((o_inst_gnt || o_data_gnt) && o_bus_req))
                else $error("grant while an access is in flight");
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned MaxBurst = 4;
    localparam int unsigned Tmo      = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        data_req = 1'b0;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic [1:0]  data_width = 2'd0;
    logic        data_we = 1'b0;
    logic        data_ze = 1'b0;
    logic        bus_ack;
    logic [31:0] bus_rdata = 32'h0;

    logic        o_inst_gnt, o_inst_rvalid, o_inst_err;
    logic [31:0] o_inst_rdata;
    logic        o_data_gnt, o_data_rvalid, o_data_err;
    logic [31:0] o_data_rdata;
    logic        o_bus_req, o_bus_we, o_bus_zeroextend;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [1:0]  o_bus_width;

    mem_arbiter #(
        .MAX_DATA_BURST(MaxBurst),
        .TIMEOUT       (Tmo)
    ) dut (
        .i_clk            (clk),
        .rst              (rst),
        .i_inst_req       (inst_req),
        .i_inst_addr      (inst_addr),
        .o_inst_gnt       (o_inst_gnt),
        .o_inst_rvalid    (o_inst_rvalid),
        .o_inst_rdata     (o_inst_rdata),
        .o_inst_err       (o_inst_err),
        .i_data_req       (data_req),
        .i_data_addr      (data_addr),
        .i_data_wdata     (data_wdata),
        .i_data_width     (data_width),
        .i_data_we        (data_we),
        .i_data_zeroextend(data_ze),
        .o_data_gnt       (o_data_gnt),
        .o_data_rvalid    (o_data_rvalid),
        .o_data_rdata     (o_data_rdata),
        .o_data_err       (o_data_err),
        .o_bus_req        (o_bus_req),
        .o_bus_addr       (o_bus_addr),
        .o_bus_wdata      (o_bus_wdata),
        .o_bus_width      (o_bus_width),
        .o_bus_we         (o_bus_we),
        .o_bus_zeroextend (o_bus_zeroextend),
        .i_bus_ack        (bus_ack),
        .i_bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus responder: ack in cycle (ack_lat+1) of each access; ack_lat<0 never acks.
    int   ack_lat = 0;
    int   req_cnt = 0;
    logic resp_ack = 1'b0;
    logic man_ack = 1'b0;
    assign bus_ack = resp_ack | man_ack;

    always @(posedge clk) begin
        #1;
        if (o_bus_req) begin
            req_cnt  = req_cnt + 1;
            resp_ack = (ack_lat >= 0) && (req_cnt == ack_lat + 1);
        end else begin
            req_cnt  = 0;
            resp_ack = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Reference model: who owns the bus, how long it has waited, how many data
    // grants have overtaken a waiting fetch, and what completes next cycle.
    // ---------------------------------------------------------------------
    bit          m_live = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_is_data = 1'b0;
    int          m_elapsed = 0;
    int          m_streak = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [1:0]  m_width = 0;
    logic        m_we = 0, m_ze = 0;
    logic        e_irv = 0, e_ierr = 0, e_drv = 0, e_derr = 0;
    logic [31:0] e_ird = 0, e_drd = 0;
    logic [1:0]  g_upd, g_cmp;

    // {data, inst}
    function automatic logic [1:0] exp_gnt();
        if (rst || m_busy) return 2'b00;
        if (data_req && !(inst_req && m_streak >= int'(MaxBurst))) return 2'b10;
        if (inst_req) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        g_upd = exp_gnt();
        e_irv = 0; e_ierr = 0; e_ird = 0;
        e_drv = 0; e_derr = 0; e_drd = 0;
        if (rst) begin
            m_busy = 0; m_is_data = 0; m_elapsed = 0; m_streak = 0;
            m_addr = 0; m_wdata = 0; m_width = 0; m_we = 0; m_ze = 0;
        end else if (m_busy) begin
            if (bus_ack) begin
                m_busy = 0;
                if (m_is_data) begin e_drv = 1; e_drd = m_we ? 32'h0 : bus_rdata; end
                else begin e_irv = 1; e_ird = bus_rdata; end
            end else begin
                m_elapsed++;
                if (m_elapsed >= int'(Tmo)) begin
                    m_busy = 0;
                    if (m_is_data) begin e_drv = 1; e_derr = 1; end
                    else begin e_irv = 1; e_ierr = 1; end
                end
            end
        end else begin
            if (g_upd[1]) begin
                m_busy = 1; m_is_data = 1; m_elapsed = 0;
                m_addr = data_addr; m_wdata = data_wdata; m_width = data_width;
                m_we = data_we; m_ze = data_ze;
                m_streak = inst_req ? ((m_streak + 1 > int'(MaxBurst)) ? int'(MaxBurst)
                                                                       : m_streak + 1) : 0;
            end else if (g_upd[0]) begin
                m_busy = 1; m_is_data = 0; m_elapsed = 0; m_streak = 0;
                m_addr = inst_addr; m_wdata = 0; m_width = 2; m_we = 0; m_ze = 0;
            end else if (!inst_req) begin
                m_streak = 0;
            end
        end
        m_live = 1'b1;
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            g_cmp = exp_gnt();
            check("cmp_inst_gnt", o_inst_gnt, g_cmp[0]);
            check("cmp_data_gnt", o_data_gnt, g_cmp[1]);
            check("cmp_inst_rvalid", o_inst_rvalid, e_irv);
            check("cmp_inst_rdata", o_inst_rdata, e_ird);
            check("cmp_inst_err", o_inst_err, e_ierr);
            check("cmp_data_rvalid", o_data_rvalid, e_drv);
            check("cmp_data_rdata", o_data_rdata, e_drd);
            check("cmp_data_err", o_data_err, e_derr);
            check("cmp_bus_req", o_bus_req, m_busy);
            check("cmp_bus_addr", o_bus_addr, m_addr);
            check("cmp_bus_wdata", o_bus_wdata, m_wdata);
            check("cmp_bus_width", o_bus_width, m_width);
            check("cmp_bus_we", o_bus_we, m_we);
            check("cmp_bus_ze", o_bus_zeroextend, m_ze);
        end
    end

    // ---------------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------------
    task automatic check_all_zero(input string tag);
        check({tag, "_inst_gnt"}, o_inst_gnt, 0);
        check({tag, "_data_gnt"}, o_data_gnt, 0);
        check({tag, "_inst_rvalid"}, o_inst_rvalid, 0);
        check({tag, "_inst_rdata"}, o_inst_rdata, 0);
        check({tag, "_data_rvalid"}, o_data_rvalid, 0);
        check({tag, "_data_rdata"}, o_data_rdata, 0);
        check({tag, "_bus_req"}, o_bus_req, 0);
        check({tag, "_bus_addr"}, o_bus_addr, 0);
        check({tag, "_bus_wdata"}, o_bus_wdata, 0);
        check({tag, "_bus_width"}, o_bus_width, 0);
    endtask

    // Starting on the cycle after a grant, count bus cycles until an rvalid.
    // Leaves the caller at the falling edge of the rvalid cycle.
    task automatic run_access(input string tag, input bit is_store,
                              output int busy, output bit seen);
        busy = 0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_inst_rvalid || o_data_rvalid) begin
                seen = 1;
                break;
            end
            if (o_bus_req) begin
                busy++;
                if (is_store) begin
                    check({tag, "_we_held"}, o_bus_we, 1);
                    check({tag, "_wdata_held"}, o_bus_wdata, 32'hDEADBEEF);
                end
            end
            tick();
        end
        if (!seen) check({tag, "_rvalid_timeout"}, 0, 1);
    endtask

    string gnt_str;
    int    busy;
    bit    seen;

    initial begin
        // Reset
        tick(); tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        // 1: fetch, ack one cycle after o_bus_req rises
        ack_lat   = 1;
        bus_rdata = 32'h00000013;
        inst_req  = 1'b1;
        inst_addr = 32'h10000000;
        @(negedge clk); check("t1_gnt_t0", o_inst_gnt, 1);
        tick(); inst_req = 1'b0;
        @(negedge clk); check("t1_bus_req_t1", o_bus_req, 1);
        check("t1_bus_addr", o_bus_addr, 32'h10000000);
        tick();
        @(negedge clk); check("t1_bus_req_t2", o_bus_req, 1);
        tick();
        @(negedge clk); check("t1_rvalid_t3", o_inst_rvalid, 1);
        check("t1_rdata", o_inst_rdata, 32'h00000013);
        check("t1_err", o_inst_err, 0);
        check("t1_bus_req_t3", o_bus_req, 0);

        // 2: both requesting continuously, zero-wait bus
        tick();
        ack_lat    = 0;
        bus_rdata  = 32'hA5A50F0F;
        inst_addr  = 32'h10000100;
        data_addr  = 32'h30000000;
        data_width = 2'd1;
        data_we    = 1'b0;
        data_ze    = 1'b1;
        inst_req   = 1'b1;
        data_req   = 1'b1;
        gnt_str    = "";
        for (int c = 0; c < 60 && gnt_str.len() < 10; c++) begin
            @(negedge clk);
            if (o_data_gnt) gnt_str = {gnt_str, "D"};
            if (o_inst_gnt) gnt_str = {gnt_str, "I"};
            check("t2_gnt_onehot", o_inst_gnt & o_data_gnt, 0);
            if (gnt_str.len() < 10) tick();
        end
        n_checks++;
        if (gnt_str != "DDDDIDDDDI") begin
            n_errors++;
            $display("FAIL t2_order: got %s, expected DDDDIDDDDI", gnt_str);
        end
        tick();
        inst_req = 1'b0;
        data_req = 1'b0;
        tick(); tick();

        // 3: store keeps its fields on the bus and returns rdata=0
        ack_lat    = 2;
        bus_rdata  = 32'hCAFEF00D;
        data_addr  = 32'h20000004;
        data_wdata = 32'hDEADBEEF;
        data_width = 2'd2;
        data_we    = 1'b1;
        data_ze    = 1'b0;
        data_req   = 1'b1;
        @(negedge clk); check("t3_gnt", o_data_gnt, 1);
        tick(); data_req = 1'b0;
        run_access("t3", 1'b1, busy, seen);
        check("t3_busy_cycles", busy, 3);
        check("t3_rvalid", o_data_rvalid, 1);
        check("t3_rdata", o_data_rdata, 0);
        check("t3_err", o_data_err, 0);

        // 4: no ack -> abort after Tmo bus cycles, then a normal access
        tick();
        ack_lat    = -1;
        data_addr  = 32'h20000008;
        data_width = 2'd0;
        data_we    = 1'b0;
        data_req   = 1'b1;
        @(negedge clk); check("t4_gnt", o_data_gnt, 1);
        tick(); data_req = 1'b0;
        run_access("t4", 1'b0, busy, seen);
        check("t4_busy_cycles", busy, 8);
        check("t4_rvalid", o_data_rvalid, 1);
        check("t4_err", o_data_err, 1);
        check("t4_rdata", o_data_rdata, 0);
        tick();
        ack_lat   = 0;
        bus_rdata = 32'h00000077;
        inst_addr = 32'h10000040;
        inst_req  = 1'b1;
        @(negedge clk); check("t4_next_gnt", o_inst_gnt, 1);
        tick(); inst_req = 1'b0;
        run_access("t4n", 1'b0, busy, seen);
        check("t4_next_rdata", o_inst_rdata, 32'h00000077);
        check("t4_next_err", o_inst_err, 0);

        // 5: reset in BUSY_I, ack pulsed the cycle after reset
        tick();
        ack_lat   = -1;
        inst_addr = 32'h10000200;
        inst_req  = 1'b1;
        @(negedge clk); check("t5_gnt", o_inst_gnt, 1);
        tick(); inst_req = 1'b0;
        tick(); rst = 1'b1;
        @(negedge clk); check("t5_busy_before_rst", o_bus_req, 1);
        tick();
        rst       = 1'b0;
        man_ack   = 1'b1;
        bus_rdata = 32'hBAD0BAD0;
        @(negedge clk); check_all_zero("t5_after_rst");
        tick(); man_ack = 1'b0;
        @(negedge clk);
        check("t5_no_irvalid", o_inst_rvalid, 0);
        check("t5_idle", o_bus_req, 0);
        tick();
        @(negedge clk); check("t5_no_irvalid2", o_inst_rvalid, 0);

        // 6: ack in the last allowed cycle beats the timeout
        tick();
        ack_lat   = 7;
        bus_rdata = 32'h12345678;
        inst_addr = 32'h10000300;
        inst_req  = 1'b1;
        @(negedge clk); check("t6_gnt", o_inst_gnt, 1);
        tick(); inst_req = 1'b0;
        run_access("t6", 1'b0, busy, seen);
        check("t6_busy_cycles", busy, 8);
        check("t6_rvalid", o_inst_rvalid, 1);
        check("t6_err", o_inst_err, 0);
        check("t6_rdata", o_inst_rdata, 32'h12345678);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
